xor_frame_accumulator: RTL and testbench

Parametrised streaming XOR accumulator. It folds a frame of WIDTH-bit words into a bitwise-XOR checksum and reports the checksum with its parity, word count and an overflow flag. Input and output both use a valid/ready handshake. It sits between a word source and a checksum consumer as the sequential successor of the 2-input `xor_gate` cell.

---
 rtl/xor_pkg.sv | 15 +
 rtl/xor_gate.sv | 15 +
 rtl/xor_word.sv | 23 ++
 rtl/xor_frame_accumulator.sv | 108 ++++++++++
 tb/tb_xor_frame_accumulator.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xor_pkg : shared state encoding for the XOR frame accumulator       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package xor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/xor_gate.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xor_gate : 2-input XOR cell                                         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module xor_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i ^ b_i;

endmodule
`default_nettype wire

// File: rtl/xor_word.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xor_word : WIDTH-bit bitwise XOR assembled from xor_gate cells      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor_gate u_gate (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .y_o (y_o[i])
    );
  end

endmodule
`default_nettype wire

// File: rtl/xor_frame_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | xor_frame_accumulator : folds a frame of words into an XOR checksum |
// | with saturating word count and sticky overflow, valid/ready I/O.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module xor_frame_accumulator
  import xor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_xor,
  output logic                               out_parity,
  output logic [$clog2(MAX_WORDS+1)-1:0]     out_count,
  output logic                               out_overflow
);

  localparam int                CNT_W   = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WORDS);

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   xor_fold;
  logic               accept;

  xor_word #(.WIDTH(WIDTH)) u_fold (
    .a_i (acc_q),
    .b_i (in_data),
    .y_o (xor_fold)
  );

  assign accept = in_valid && in_ready_q;

  // First word of a frame loads directly so nothing leaks from the previous frame.
  always_comb begin
    acc_d = (state_q == IDLE) ? in_data : xor_fold;
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    ovf_d = ovf_q | (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_xor      = acc_q;
  assign out_parity   = ^acc_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_frame_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_xor_frame_accumulator : scoreboard bench, WIDTH=8, MAX_WORDS=4   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_xor_frame_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_xor;
  logic       out_parity;
  logic [2:0] out_count;
  logic       out_overflow;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [2:0] c;
    logic       o;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] m_acc = 8'h00;
  logic [2:0] m_cnt = 3'd0;
  logic       m_ovf = 1'b0;

  xor_frame_accumulator #(.WIDTH(8), .MAX_WORDS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xor      (out_xor),
    .out_parity   (out_parity),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_word(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL send_timeout: in_ready actual %b required 1", in_ready);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    m_acc = (m_cnt == 3'd0) ? d : (m_acc ^ d);
    if (m_cnt == 3'd4) m_ovf = 1'b1;
    else m_cnt = m_cnt + 3'd1;
    if (last) begin
      exp_q.push_back('{x: m_acc, c: m_cnt, o: m_ovf});
      m_acc = 8'h00; m_cnt = 3'd0; m_ovf = 1'b0;
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      n_cmp++; n_mis++;
      $display("FAIL scoreboard_empty: queue size actual 0 required >0");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_in_ready: actual %b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_out_valid: actual %b required 0", out_valid); end
    n_cmp++; if ({out_xor, out_parity, out_count, out_overflow} !== 13'd0) begin
      n_mis++;
      $display("FAIL rst_outputs: actual xor=%h par=%b cnt=%0d ovf=%b required all 0",
               out_xor, out_parity, out_count, out_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL rst_release_idle: actual rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_multi_word();
    out_ready = 1'b1;
    send_word(8'h0F, 1'b0);
    send_word(8'hF0, 1'b0);
    send_word(8'hAA, 1'b1);
    pop_exp();
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL multi_latency: out_valid actual %b required 1", out_valid); end
    n_cmp++; if ({out_xor, out_parity, out_count, out_overflow} !== {e.x, ^e.x, e.c, e.o}) begin
      n_mis++;
      $display("FAIL multi_result: actual xor=%h par=%b cnt=%0d ovf=%b required xor=%h par=%b cnt=%0d ovf=%b",
               out_xor, out_parity, out_count, out_overflow, e.x, ^e.x, e.c, e.o);
    end
    n_cmp++; if (out_xor !== 8'h55) begin n_mis++; $display("FAIL multi_xor_const: actual %h required 55", out_xor); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL multi_hold_one_cycle: actual vld=%b rdy=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_word();
    send_word(8'h01, 1'b1);
    pop_exp();
    n_cmp++; if (out_valid !== 1'b1 || {out_xor, out_parity, out_count, out_overflow} !== {e.x, ^e.x, e.c, e.o}) begin
      n_mis++;
      $display("FAIL single_result: actual vld=%b xor=%h par=%b cnt=%0d required vld=1 xor=%h par=%b cnt=%0d",
               out_valid, out_xor, out_parity, out_count, e.x, ^e.x, e.c);
    end
    n_cmp++; if (out_parity !== 1'b1) begin n_mis++; $display("FAIL single_parity: actual %b required 1", out_parity); end
    @(negedge clk);
    send_word(8'h80, 1'b0);
    send_word(8'h02, 1'b1);
    pop_exp();
    n_cmp++; if ({out_xor, out_count} !== {e.x, e.c}) begin
      n_mis++; $display("FAIL single_no_carry: actual xor=%h cnt=%0d required xor=%h cnt=%0d", out_xor, out_count, e.x, e.c);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    send_word(8'h3C, 1'b1);
    pop_exp();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1; in_data = 8'hFF; in_last = 1'b1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                   {out_xor, out_parity, out_count, out_overflow} !== {e.x, ^e.x, e.c, e.o}) begin
        n_mis++;
        $display("FAIL bp_hold_%0d: actual vld=%b rdy=%b xor=%h cnt=%0d required vld=1 rdy=0 xor=%h cnt=%0d",
                 i, out_valid, in_ready, out_xor, out_count, e.x, e.c);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_mis++; $display("FAIL bp_still_held: actual vld=%b rdy=%b required 1/0", out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL bp_release: actual vld=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    send_word(8'h05, 1'b1);
    pop_exp();
    n_cmp++; if ({out_xor, out_count, out_overflow} !== {e.x, e.c, e.o}) begin
      n_mis++; $display("FAIL bp_ignored_pulses: actual xor=%h cnt=%0d required xor=%h cnt=%0d", out_xor, out_count, e.x, e.c);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [7:0] words [6];
    words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    for (int i = 0; i < 6; i++) send_word(words[i], i == 5);
    pop_exp();
    n_cmp++; if ({out_xor, out_parity, out_count, out_overflow} !== {e.x, ^e.x, e.c, e.o}) begin
      n_mis++;
      $display("FAIL ovf_result: actual xor=%h par=%b cnt=%0d ovf=%b required xor=%h par=%b cnt=%0d ovf=%b",
               out_xor, out_parity, out_count, out_overflow, e.x, ^e.x, e.c, e.o);
    end
    n_cmp++; if (out_overflow !== 1'b1 || out_count !== 3'd4) begin
      n_mis++; $display("FAIL ovf_const: actual ovf=%b cnt=%0d required 1/4", out_overflow, out_count);
    end
    @(negedge clk);
    send_word(8'h07, 1'b1);
    pop_exp();
    n_cmp++; if ({out_xor, out_count, out_overflow} !== {e.x, e.c, e.o}) begin
      n_mis++; $display("FAIL ovf_cleared: actual xor=%h cnt=%0d ovf=%b required xor=%h cnt=%0d ovf=%b",
                        out_xor, out_count, out_overflow, e.x, e.c, e.o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe_gaps();
    out_ready = 1'b1;
    send_word(8'hFF, 1'b0);
    send_word(8'h11, 1'b0);
    #1 rst_n = 1'b0;
    exp_q.delete(); m_acc = 8'h00; m_cnt = 3'd0; m_ovf = 1'b0;
    #1;
    n_cmp++; if (out_count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL mid_async_reset: actual cnt=%0d vld=%b rdy=%b required 0/0/1", out_count, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(8'h12, 1'b0);
    repeat (3) @(negedge clk);
    send_word(8'h34, 1'b1);
    pop_exp();
    n_cmp++; if ({out_xor, out_count, out_overflow} !== {e.x, e.c, e.o} || out_xor !== 8'h26) begin
      n_mis++; $display("FAIL gap_result: actual xor=%h cnt=%0d ovf=%b required xor=%h cnt=%0d ovf=%b",
                        out_xor, out_count, out_overflow, e.x, e.c, e.o);
    end
    @(negedge clk);
    // Reset while a result is being presented must drop out_valid before any clock edge.
    out_ready = 1'b0;
    send_word(8'h99, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL hold_before_reset: out_valid actual %b required 1", out_valid); end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_xor !== 8'h00 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL hold_async_reset: actual vld=%b xor=%h rdy=%b required 0/00/1", out_valid, out_xor, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multi_word();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_reset_midframe_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
